// File: rtl/video_input_monitor.sv
// video_input_monitor
//   Pixel-clock front end ahead of edge detection. Registers the raw
//   RGB/VSYNC/HSYNC/DE stream once and forwards it with a fixed latency of
//   one cycle. It measures the active width of each line and the line count
//   of each frame. After LOCK_FRAMES consecutive frames of exactly HACT x VACT
//   it reports timing lock.
//
// Ports
//   I_PCLK        in   1   pixel clock, sole clock
//   I_RST         in   1   synchronous reset, active-high
//   I_PIX_DATA    in   24  RGB pixel data
//   I_VSYNC       in   1   vertical sync, active level SYNC_POL
//   I_HSYNC       in   1   horizontal sync, active level SYNC_POL
//   I_DE          in   1   data enable
//   O_PIX_DATA    out  24  registered pixel data
//   O_VSYNC       out  1   registered VSYNC, polarity unchanged
//   O_HSYNC       out  1   registered HSYNC, polarity unchanged
//   O_DE          out  1   registered data enable
//   O_LOCKED      out  1   timing lock status
//   O_FRAME_START out  1   one-cycle pulse on the VSYNC leading edge
//   O_FRAME_ERR   out  1   one-cycle pulse when an evaluated frame fails
//   O_HACT_CNT    out  12  width of the last completed line
//   O_VACT_CNT    out  12  line count of the last completed frame
//
// Build option
//   VIDEO_MON_BLANK_EN : while unlocked, O_PIX_DATA is forced to 0 and O_DE
//                        to 0. The syncs and the measurement are unaffected.
module video_input_monitor #(
  parameter int unsigned HACT        = 640,
  parameter int unsigned VACT        = 480,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter logic        SYNC_POL    = 1'b1
) (
  input  logic        I_PCLK,
  input  logic        I_RST,
  input  logic [23:0] I_PIX_DATA,
  input  logic        I_VSYNC,
  input  logic        I_HSYNC,
  input  logic        I_DE,
  output logic [23:0] O_PIX_DATA,
  output logic        O_VSYNC,
  output logic        O_HSYNC,
  output logic        O_DE,
  output logic        O_LOCKED,
  output logic        O_FRAME_START,
  output logic        O_FRAME_ERR,
  output logic [11:0] O_HACT_CNT,
  output logic [11:0] O_VACT_CNT
);

  localparam logic [11:0] HACT_W = 12'(HACT);
  localparam logic [11:0] VACT_W = 12'(VACT);
  localparam logic [3:0]  LOCK_W = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic [23:0] pix_p0;
  logic        vs_p0, hs_p0, de_p0;
  logic        vs_p1, de_p1;

  logic [11:0] hcnt, vcnt, hact_cnt, vact_cnt;
  logic        line_err;

  state_t      state_q, state_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic        frame_err_q, frame_err_d;

  // ---- stage 0: input register, also the forwarded stream ----
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      pix_p0 <= '0;
      vs_p0  <= 1'b0;
      hs_p0  <= 1'b0;
      de_p0  <= 1'b0;
    end else begin
      pix_p0 <= I_PIX_DATA;
      vs_p0  <= I_VSYNC;
      hs_p0  <= I_HSYNC;
      de_p0  <= I_DE;
    end
  end

  // ---- stage 1: delayed copy used only for edge detection ----
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      vs_p1 <= 1'b0;
      de_p1 <= 1'b0;
    end else begin
      vs_p1 <= vs_p0;
      de_p1 <= de_p0;
    end
  end

  logic vs_edge, de_rise, de_fall, line_bad, err_close, frame_good;
  logic [11:0] vcnt_close;

  assign vs_edge = (vs_p0 == SYNC_POL) && (vs_p1 != SYNC_POL);
  assign de_rise = de_p0 && !de_p1;
  assign de_fall = !de_p0 && de_p1;
  assign line_bad = (hcnt != HACT_W);

  // A line that closes in the same cycle as the frame edge still belongs
  // to the frame that is ending, so fold it in before judging.
  assign vcnt_close = de_fall ? sat_inc12(vcnt) : vcnt;
  assign err_close  = line_err || (de_fall && line_bad);
  assign frame_good = (vcnt_close == VACT_W) && !err_close;

  // ---- measurement: line width and line count ----
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      hcnt     <= '0;
      vcnt     <= '0;
      line_err <= 1'b0;
      hact_cnt <= '0;
      vact_cnt <= '0;
    end else begin
      // The rise cycle itself is the first active pixel.
      if (de_rise)
        hcnt <= 12'd1;
      else if (de_p0)
        hcnt <= sat_inc12(hcnt);

      if (de_fall)
        hact_cnt <= hcnt;

      if (vs_edge) begin
        vact_cnt <= vcnt_close;
        vcnt     <= '0;
        line_err <= 1'b0;
      end else if (de_fall) begin
        vcnt     <= sat_inc12(vcnt);
        line_err <= line_err || line_bad;
      end
    end
  end

  // ---- lock state machine ----
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      state_q     <= S_IDLE;
      gcnt_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    frame_err_d = 1'b0;
    if (vs_edge) begin
      unique case (state_q)
        S_IDLE: begin
          // The partial frame seen before the first edge is not judged.
          state_d = S_ACQ;
          gcnt_d  = '0;
        end
        S_ACQ: begin
          if (frame_good) begin
            gcnt_d = gcnt_q + 4'd1;
            if ((gcnt_q + 4'd1) == LOCK_W)
              state_d = S_LOCKED;
          end else begin
            gcnt_d      = '0;
            frame_err_d = 1'b1;
          end
        end
        S_LOCKED: begin
          if (!frame_good) begin
            state_d     = S_ACQ;
            gcnt_d      = '0;
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end
      endcase
    end
  end

  assign O_LOCKED      = (state_q == S_LOCKED);
  assign O_FRAME_START = vs_edge;
  assign O_FRAME_ERR   = frame_err_q;
  assign O_HACT_CNT    = hact_cnt;
  assign O_VACT_CNT    = vact_cnt;
  assign O_VSYNC       = vs_p0;
  assign O_HSYNC       = hs_p0;

`ifdef VIDEO_MON_BLANK_EN
  assign O_PIX_DATA = O_LOCKED ? pix_p0 : 24'h0;
  assign O_DE       = O_LOCKED && de_p0;
`else
  assign O_PIX_DATA = pix_p0;
  assign O_DE       = de_p0;
`endif

endmodule
